// File: rtl/ram_write_control_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared constants for the VG8020 RAM write-enable decoder.
//   STROBE_ACTIVE : asserted level of the buffered bus strobes (active low).
//   DEF_CNT_W     : default width of the write-event counter.
// Optional build macro used by the decoder: RAM_WE_REGISTERED_EN.
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

  localparam logic STROBE_ACTIVE = 1'b0;
  localparam int   DEF_CNT_W     = 16;

endpackage : ram_ctrl_pkg

// File: rtl/ram_write_control_if.sv
// ----------------------------------------------------------------------------
// ram_write_control_if
// Strobe and monitor signals between the CPU bus buffers and the RAM control.
//   nrdd     : buffered read strobe, active low      (master -> slave)
//   nmreqd   : buffered memory request, active low   (master -> slave)
//   nwe      : decoded RAM write-enable              (slave -> master)
//   we_rise  : one-cycle pulse on an nwe 0->1 edge   (slave -> master)
//   we_count : number of nwe 0->1 edges since reset  (slave -> master)
// ----------------------------------------------------------------------------
interface ram_write_control_if #(
  parameter int CNT_W = ram_ctrl_pkg::DEF_CNT_W
);

  logic             nrdd;
  logic             nmreqd;
  logic             nwe;
  logic             we_rise;
  logic [CNT_W-1:0] we_count;

  modport master (
    output nrdd,
    output nmreqd,
    input  nwe,
    input  we_rise,
    input  we_count
  );

  modport slave (
    input  nrdd,
    input  nmreqd,
    output nwe,
    output we_rise,
    output we_count
  );

endinterface : ram_write_control_if

// File: rtl/ram_write_control_edge_counter.sv
// ----------------------------------------------------------------------------
// ram_edge_counter
// Registered rising-edge detector with a wrapping event counter.
//   clk     : system clock
//   rst     : synchronous, active-high reset
//   level_i : level being monitored
//   rise_o  : registered one-cycle pulse when level_i goes 0->1
//   count_o : number of detected rising edges, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module ram_edge_counter
  import ram_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             level_i,
  output logic             rise_o,
  output logic [CNT_W-1:0] count_o
);

  logic             level_q;
  logic             rise_d;
  logic             rise_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Edge detect against the previous sample and next counter value.
  always_comb begin
    rise_d = level_i & ~level_q;
    if (rise_d) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Monitor state; reset wins over a coincident edge so it is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      count_q <= '0;
    end else begin
      level_q <= level_i;
      rise_q  <= rise_d;
      count_q <= count_d;
    end
  end

  assign rise_o  = rise_q;
  assign count_o = count_q;

endmodule : ram_edge_counter

// File: rtl/ram_write_control.sv
// ----------------------------------------------------------------------------
// ram_write_control
// RAM write-enable decoder: nwe is asserted only while both buffered strobes
// are at their active (low) level. A clocked monitor reports nwe rising edges.
//   clk : system clock (monitor, and the optional output register)
//   rst : synchronous, active-high reset; never gates the combinational decode
//   bus : ram_write_control_if.slave (nrdd, nmreqd in; nwe, we_rise, we_count out)
// Build macro RAM_WE_REGISTERED_EN: when defined, nwe is taken from a
// flip-flop (one cycle of latency, reset to 0); otherwise nwe is combinational.
// ----------------------------------------------------------------------------
module ram_write_control
  import ram_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  ram_write_control_if.slave        bus
);

  logic nwe_d;
  logic nwe_s;

  // Equality compares keep X/Z on a strobe visible on nwe instead of masking it.
  assign nwe_d = (bus.nrdd == STROBE_ACTIVE) & (bus.nmreqd == STROBE_ACTIVE);

`ifdef RAM_WE_REGISTERED_EN
  logic nwe_q;

  // Optional output register on the write-enable line.
  always_ff @(posedge clk) begin
    if (rst) begin
      nwe_q <= 1'b0;
    end else begin
      nwe_q <= nwe_d;
    end
  end

  assign nwe_s = nwe_q;
`else
  assign nwe_s = nwe_d;
`endif

  assign bus.nwe = nwe_s;

  // The monitor always watches the value actually driven on nwe.
  ram_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk     (clk),
    .rst     (rst),
    .level_i (nwe_s),
    .rise_o  (bus.we_rise),
    .count_o (bus.we_count)
  );

endmodule : ram_write_control

// File: tb/tb_ram_write_control.sv
// ----------------------------------------------------------------------------
// tb_ram_write_control
// Directed bench for ram_write_control: a 16-bit counter instance for the
// decode/monitor sequence and a 4-bit counter instance for wrap-around.
// ----------------------------------------------------------------------------
module tb_ram_write_control;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  ram_write_control_if #(.CNT_W(16)) bus  ();
  ram_write_control_if #(.CNT_W(4))  bus4 ();

  ram_write_control #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ram_write_control #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  // Clock only toggles once enabled, so the first decode checks run clockless.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input logic rd, input logic mreq);
    bus.nrdd   = rd;
    bus.nmreqd = mreq;
  endtask

  initial begin
    strobes(1'b1, 1'b1);
    bus4.nrdd   = 1'b1;
    bus4.nmreqd = 1'b1;

`ifndef RAM_WE_REGISTERED_EN
    // Truth table with no clock running.
    #25; check("nwe_11", 32'(bus.nwe), 32'd0);
    strobes(1'b1, 1'b0);
    #25; check("nwe_10", 32'(bus.nwe), 32'd0);
    strobes(1'b0, 1'b0);
    #25; check("nwe_00", 32'(bus.nwe), 32'd1);
    strobes(1'b0, 1'b1);
    #25; check("nwe_01", 32'(bus.nwe), 32'd0);
    strobes(1'b1, 1'b1);
`endif

    // Reset with clock running.
    rst    = 1'b1;
    clk_en = 1'b1;
    tick();
    tick();
    check("rst_rise",  32'(bus.we_rise),  32'd0);
    check("rst_count", 32'(bus.we_count), 32'd0);
    check("rst_nwe",   32'(bus.nwe),      32'd0);
    rst = 1'b0;

`ifndef RAM_WE_REGISTERED_EN
    // Only one strobe active: no write, no pulse.
    strobes(1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("half_nwe",  32'(bus.nwe),      32'd0);
      check("half_rise", 32'(bus.we_rise),  32'd0);
    end

    // Three 4-cycle write windows separated by 2 idle cycles.
    for (int w = 0; w < 3; w++) begin
      strobes(1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
        tick();
        check("win_rise",  32'(bus.we_rise),  (c == 0) ? 32'd1 : 32'd0);
        check("win_count", 32'(bus.we_count), 32'(w + 1));
      end
      strobes(1'b1, 1'b1);
      for (int c = 0; c < 2; c++) begin
        tick();
        check("idle_rise", 32'(bus.we_rise), 32'd0);
        check("idle_nwe",  32'(bus.nwe),     32'd0);
      end
    end
    check("win_total", 32'(bus.we_count), 32'd3);

    // Reset while writing: decode ungated, count cleared, edge not counted.
    rst = 1'b1;
    strobes(1'b0, 1'b0);
    #1;
    check("rstw_nwe_comb", 32'(bus.nwe), 32'd1);
    tick();
    check("rstw_count", 32'(bus.we_count), 32'd0);
    check("rstw_rise",  32'(bus.we_rise),  32'd0);
    check("rstw_nwe",   32'(bus.nwe),      32'd1);
    rst = 1'b0;
    // The sampled nwe was cleared to 0 by reset while nwe itself is 1, so
    // the first edge after release sees a 0->1 transition and counts it.
    tick();
    check("rel_count", 32'(bus.we_count), 32'd1);
    check("rel_rise",  32'(bus.we_rise),  32'd1);
    tick();
    check("rel_count2", 32'(bus.we_count), 32'd1);
    check("rel_rise2",  32'(bus.we_rise),  32'd0);
    strobes(1'b1, 1'b1);
    tick();
`else
    // Registered nwe: one cycle to nwe, two cycles to we_rise.
    strobes(1'b0, 1'b0);
    #1;
    check("reg_nwe_nolat", 32'(bus.nwe), 32'd0);
    tick();
    check("reg_nwe_n1",  32'(bus.nwe),     32'd1);
    check("reg_rise_n1", 32'(bus.we_rise), 32'd0);
    tick();
    check("reg_rise_n2",  32'(bus.we_rise),  32'd1);
    check("reg_count_n2", 32'(bus.we_count), 32'd1);
    tick();
    check("reg_rise_n3",  32'(bus.we_rise),  32'd0);
    check("reg_count_n3", 32'(bus.we_count), 32'd1);
    rst = 1'b1;
    tick();
    check("reg_rst_nwe",   32'(bus.nwe),      32'd0);
    check("reg_rst_count", 32'(bus.we_count), 32'd0);
    rst = 1'b0;
    strobes(1'b1, 1'b1);
    tick();
    tick();
`endif

    // Wrap-around on the 4-bit counter: 16 events -> 0, 17 events -> 1.
    check("wrap_start", 32'(bus4.we_count), 32'd0);
    for (int i = 0; i < 17; i++) begin
      bus4.nrdd   = 1'b0;
      bus4.nmreqd = 1'b0;
      tick();
      bus4.nrdd   = 1'b1;
      bus4.nmreqd = 1'b1;
      tick();
      if (i == 15) check("wrap_16", 32'(bus4.we_count), 32'd0);
    end
    tick();
    check("wrap_17", 32'(bus4.we_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_ram_write_control
